// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive path (framer today, transmitter later).
package gmii_pkg;

   // Line bytes that delimit the start of an Ethernet frame
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Reflected CRC-32 (IEEE 802.3) constants
   localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

   // FCS length, which is also the depth of the payload hold-back line
   localparam int          DLY_DEPTH     = 4;

   // Widths of the length field and the statistics counters
   localparam int          LEN_W         = 11;
   localparam int          CNT_W         = 16;

   // Receive framer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32.
// Purely combinational so both the receive framer and a future transmitter can share it.
module crc32_d8
   import gmii_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   // Shift the eight data bits through the LFSR, least significant bit first
   always_comb begin
      logic [31:0] w_acc;
      w_acc = i_crc;
      for (int i = 0; i < 8; i++) begin
         if (w_acc[0] ^ i_data[i]) begin
            w_acc = (w_acc >> 1) ^ CRC_POLY;
         end else begin
            w_acc = w_acc >> 1;
         end
      end
      o_crc = w_acc;
   end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: hunts preamble/SFD, strips the FCS with a 4-byte hold-back
// line, checks CRC-32 and length, and keeps frame / bad-frame statistics.
module gmii_rx_framer
   import gmii_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic             gmii_gtx_clk,
   input  logic             rst_n,
   input  logic             gmii_en,
   input  logic [7:0]       gmii_din,
   output logic             rx_dv,
   output logic [7:0]       rx_data,
   output logic             rx_sof,
   output logic             rx_done,
   output logic             rx_crc_ok,
   output logic             rx_len_err,
   output logic [LEN_W-1:0] rx_len,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   localparam logic [2:0]  FILL_FULL = 3'(DLY_DEPTH);
   localparam logic [31:0] MIN_U     = 32'(MIN_FRAME);
   localparam logic [31:0] MAX_U     = 32'(MAX_FRAME);

   // Frame length counter that sticks at all-ones instead of wrapping
   function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] len);
      if (&len) begin
         return len;
      end
      return len + 1'b1;
   endfunction

   // Length outside [MIN_FRAME, MAX_FRAME]; a saturated length always exceeds any sane MAX
   function automatic logic len_is_bad(input logic [LEN_W-1:0] len);
      logic [31:0] len32;
      len32 = {{(32-LEN_W){1'b0}}, len};
      return (len32 < MIN_U) || (len32 > MAX_U) || (&len);
   endfunction

   rx_state_t                    r_state;
   logic [DLY_DEPTH-1:0][7:0]    r_dly;
   logic [2:0]                   r_fill;
   logic [31:0]                  r_crc;
   logic [LEN_W-1:0]             r_len;
   logic                         r_sof_pend;

   logic                         r_dv;
   logic [7:0]                   r_data;
   logic                         r_sof;
   logic                         r_done;
   logic                         r_crc_ok;
   logic                         r_len_err;
   logic [LEN_W-1:0]             r_len_out;
   logic [CNT_W-1:0]             r_frame_cnt;
   logic [CNT_W-1:0]             r_bad_cnt;

   logic [31:0]                  w_crc_next;
   logic                         w_crc_good;
   logic                         w_len_bad;

   crc32_d8 u_crc (
      .i_crc  (r_crc),
      .i_data (gmii_din),
      .o_crc  (w_crc_next)
   );

   // End-of-frame status is judged on the totals accumulated up to the last byte
   assign w_crc_good = (r_crc == CRC_RESIDUE);
   assign w_len_bad  = len_is_bad(r_len);

   // Framer FSM with the hold-back line, CRC/length accumulation and registered outputs
   always_ff @(posedge gmii_gtx_clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_dly       <= '0;
         r_fill      <= '0;
         r_crc       <= CRC_INIT;
         r_len       <= '0;
         r_sof_pend  <= 1'b0;
         r_dv        <= 1'b0;
         r_data      <= '0;
         r_sof       <= 1'b0;
         r_done      <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_len_err   <= 1'b0;
         r_len_out   <= '0;
         r_frame_cnt <= '0;
         r_bad_cnt   <= '0;
      end else begin
         // Strobes are single-cycle unless re-asserted below
         r_dv   <= 1'b0;
         r_sof  <= 1'b0;
         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (gmii_en) begin
                  r_state <= (gmii_din == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
               end
            end

            ST_PREAMBLE: begin
               if (!gmii_en) begin
                  // Preamble with no SFD is not a frame: no status strobe
                  r_state <= ST_IDLE;
               end else if (gmii_din == SFD_BYTE) begin
                  r_state    <= ST_DATA;
                  r_crc      <= CRC_INIT;
                  r_len      <= '0;
                  r_fill     <= '0;
                  r_sof_pend <= 1'b1;
               end else if (gmii_din != PREAMBLE_BYTE) begin
                  r_state <= ST_DROP;
               end
            end

            ST_DATA: begin
               if (gmii_en) begin
                  r_dly <= {r_dly[DLY_DEPTH-2:0], gmii_din};
                  r_crc <= w_crc_next;
                  r_len <= len_sat_inc(r_len);
                  // Only a byte pushed out by a newer one is payload; the final four are FCS
                  if (r_fill == FILL_FULL) begin
                     r_dv       <= 1'b1;
                     r_data     <= r_dly[DLY_DEPTH-1];
                     r_sof      <= r_sof_pend;
                     r_sof_pend <= 1'b0;
                  end else begin
                     r_fill <= r_fill + 3'd1;
                  end
               end else begin
                  // End of frame: report status, bump statistics, discard the held FCS bytes
                  r_state     <= ST_IDLE;
                  r_done      <= 1'b1;
                  r_crc_ok    <= w_crc_good;
                  r_len_err   <= w_len_bad;
                  r_len_out   <= r_len;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                  if (!w_crc_good || w_len_bad) begin
                     r_bad_cnt <= r_bad_cnt + 1'b1;
                  end
                  r_fill      <= '0;
                  r_sof_pend  <= 1'b0;
               end
            end

            ST_DROP: begin
               if (!gmii_en) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_dv      = r_dv;
   assign rx_data    = r_data;
   assign rx_sof     = r_sof;
   assign rx_done    = r_done;
   assign rx_crc_ok  = r_crc_ok;
   assign rx_len_err = r_len_err;
   assign rx_len     = r_len_out;
   assign frame_cnt  = r_frame_cnt;
   assign bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer: a table of frame-level vectors, hand-written
// back-to-back and mid-frame reset sequences, and randomized frames scored against a
// frame-level reference model (payload = all but last 4 bytes, FCS compared with a
// freshly computed Ethernet CRC, length rules applied to the byte count).
`timescale 1ns/1ps
module tb_gmii_rx_framer;

   localparam int MIN_FRAME = 64;
   localparam int MAX_FRAME = 1518;

   typedef logic [7:0] byte_q_t [$];

   typedef struct {
      int ok;
      int ok_dc;
      int lerr;
      int len;
   } done_t;

   typedef struct {
      int pre_n;
      int bad_pre;
      int n;
      int flip;
      int e_dv;
      int e_done;
      int e_ok;
      int ok_dc;
      int e_lerr;
      int e_len;
      int e_bad;
   } vec_t;

   logic        gmii_gtx_clk = 1'b0;
   logic        rst_n        = 1'b1;
   logic        gmii_en      = 1'b0;
   logic [7:0]  gmii_din     = 8'h00;
   logic        rx_dv;
   logic [7:0]  rx_data;
   logic        rx_sof;
   logic        rx_done;
   logic        rx_crc_ok;
   logic        rx_len_err;
   logic [10:0] rx_len;
   logic [15:0] frame_cnt;
   logic [15:0] bad_cnt;

   always #5 gmii_gtx_clk = ~gmii_gtx_clk;

   gmii_rx_framer #(
      .MIN_FRAME (MIN_FRAME),
      .MAX_FRAME (MAX_FRAME)
   ) dut (
      .gmii_gtx_clk (gmii_gtx_clk),
      .rst_n        (rst_n),
      .gmii_en      (gmii_en),
      .gmii_din     (gmii_din),
      .rx_dv        (rx_dv),
      .rx_data      (rx_data),
      .rx_sof       (rx_sof),
      .rx_done      (rx_done),
      .rx_crc_ok    (rx_crc_ok),
      .rx_len_err   (rx_len_err),
      .rx_len       (rx_len),
      .frame_cnt    (frame_cnt),
      .bad_cnt      (bad_cnt)
   );

   int      n_cmp = 0;
   int      n_fail = 0;
   int      cyc = 0;
   byte_q_t exp_q;
   int      exp_sof_q [$];
   done_t   done_q [$];
   bit      sb_en = 1'b1;
   bit      use_done_q = 1'b0;
   int      dv_cnt = 0;
   int      done_cnt = 0;
   int      sof_edge = 0;
   int      done_edge = 0;
   int      body0_edge = 0;
   int      last_en_edge = 0;
   logic    last_ok, last_lerr;
   logic [10:0] last_len;
   int      exp_fc = 0;
   int      exp_bc = 0;
   vec_t    vt [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Standard Ethernet FCS of the first n bytes (complemented CRC-32)
   function automatic logic [31:0] eth_fcs(input byte_q_t d, input int n);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, d[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   // Post-SFD bytes: n-4 data bytes (counting pattern or random) then a correct FCS
   function automatic byte_q_t make_body(input int n, input bit rnd, input bit flip);
      byte_q_t     b;
      logic [31:0] f;
      if (n < 4) begin
         for (int i = 0; i < n; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
         return b;
      end
      for (int i = 0; i < n - 4; i++) b.push_back(rnd ? 8'($urandom) : 8'(i));
      f = eth_fcs(b, n - 4);
      b.push_back(f[7:0] ^ (flip ? 8'h01 : 8'h00));
      b.push_back(f[15:8]);
      b.push_back(f[23:16]);
      b.push_back(f[31:24]);
      return b;
   endfunction

   function automatic byte_q_t make_pre(input int n);
      byte_q_t p;
      for (int i = 0; i < n; i++) p.push_back(8'h55);
      p.push_back(8'hD5);
      return p;
   endfunction

   // Reference model: what a received frame must produce at the output
   task automatic model_frame(input bit accepted, input byte_q_t body);
      int    n;
      done_t d;
      n = body.size();
      if (!accepted) return;
      for (int i = 0; i < n - 4; i++) begin
         exp_q.push_back(body[i]);
         exp_sof_q.push_back((i == 0) ? 1 : 0);
      end
      d.ok_dc = (n < 4) ? 1 : 0;
      d.ok    = ((n >= 4) && ({body[n-1], body[n-2], body[n-3], body[n-4]} == eth_fcs(body, n - 4))) ? 1 : 0;
      d.lerr  = ((n < MIN_FRAME) || (n > MAX_FRAME)) ? 1 : 0;
      d.len   = (n > 2047) ? 2047 : n;
      if (use_done_q) done_q.push_back(d);
      exp_fc++;
      if (d.ok == 0 || d.lerr == 1) exp_bc++;
   endtask

   task automatic observe();
      logic [7:0] eb;
      int         es;
      done_t      d;
      if (!sb_en) return;
      if (rx_dv === 1'b1) begin
         dv_cnt++;
         if (rx_sof === 1'b1) sof_edge = cyc;
         check("dv_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            es = exp_sof_q.pop_front();
            check("rx_data", 64'(rx_data), 64'(eb));
            check("rx_sof", 64'(rx_sof), 64'(es));
         end
      end else if (rx_sof === 1'b1) begin
         check("sof_needs_dv", 64'(rx_dv), 64'd1);
      end
      if (rx_done === 1'b1) begin
         done_cnt++;
         done_edge = cyc;
         last_ok   = rx_crc_ok;
         last_lerr = rx_len_err;
         last_len  = rx_len;
         if (use_done_q) begin
            check("done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) begin
               d = done_q.pop_front();
               if (d.ok_dc == 0) check("q_crc_ok", 64'(rx_crc_ok), 64'(d.ok));
               check("q_len_err", 64'(rx_len_err), 64'(d.lerr));
               check("q_len", 64'(rx_len), 64'(d.len));
            end
         end
      end
   endtask

   // One clock: drive inputs, wait for the edge, look at outputs 1 ns later
   task automatic cycle(input bit en, input logic [7:0] din);
      gmii_en  = en;
      gmii_din = din;
      @(posedge gmii_gtx_clk);
      cyc++;
      #1;
      observe();
   endtask

   task automatic send_frame(input byte_q_t pre, input byte_q_t body, input int gap);
      foreach (pre[i]) cycle(1'b1, pre[i]);
      foreach (body[i]) begin
         cycle(1'b1, body[i]);
         if (i == 0) body0_edge = cyc;
      end
      last_en_edge = cyc;
      for (int g = 0; g < gap; g++) cycle(1'b0, 8'h00);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h00);
      rst_n = 1'b1;
      exp_q.delete();
      exp_sof_q.delete();
      done_q.delete();
      exp_fc = 0;
      exp_bc = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_dv"},      64'(rx_dv), 64'd0);
      check({tag, "_rx_sof"},     64'(rx_sof), 64'd0);
      check({tag, "_rx_done"},    64'(rx_done), 64'd0);
      check({tag, "_rx_crc_ok"},  64'(rx_crc_ok), 64'd0);
      check({tag, "_rx_len_err"}, 64'(rx_len_err), 64'd0);
      check({tag, "_rx_data"},    64'(rx_data), 64'd0);
      check({tag, "_rx_len"},     64'(rx_len), 64'd0);
      check({tag, "_frame_cnt"},  64'(frame_cnt), 64'd0);
      check({tag, "_bad_cnt"},    64'(bad_cnt), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t pre, body, b2;
      vec_t    v;
      int      dv0, dc0, n, pre_n, pos, gap;
      logic [7:0] r;

      // pre_n bad n flip | dv done ok okdc lerr len bad
      vt[0]  = '{7, 0,   64, 0,   60, 1, 1, 0, 0,   64, 0};
      vt[1]  = '{7, 0,   64, 1,   60, 1, 0, 0, 0,   64, 1};
      vt[2]  = '{7, 1,   64, 0,    0, 0, 0, 0, 0,    0, 0};
      vt[3]  = '{7, 0, 1600, 0, 1596, 1, 1, 0, 1, 1600, 1};
      vt[4]  = '{7, 0,   10, 0,    6, 1, 1, 0, 1,   10, 1};
      vt[5]  = '{7, 0,    4, 0,    0, 1, 1, 0, 1,    4, 1};
      vt[6]  = '{7, 0,    3, 0,    0, 1, 0, 1, 1,    3, 1};
      vt[7]  = '{7, 0, 1518, 0, 1514, 1, 1, 0, 0, 1518, 0};
      vt[8]  = '{7, 0, 1519, 0, 1515, 1, 1, 0, 1, 1519, 1};
      vt[9]  = '{7, 0, 2100, 0, 2096, 1, 1, 0, 1, 2047, 1};
      vt[10] = '{7, 0,   63, 0,   59, 1, 1, 0, 1,   63, 1};
      vt[11] = '{1, 0,   64, 0,   60, 1, 1, 0, 0,   64, 0};
      vt[12] = '{7, 0,    0, 0,    0, 1, 0, 1, 1,    0, 1};

      // Reset state
      reset_dut();
      check_all_zero("reset");

      // Table-driven frames, each from a fresh reset
      use_done_q = 1'b0;
      for (int k = 0; k < 13; k++) begin
         v = vt[k];
         reset_dut();
         body = make_body(v.n, 1'b0, v.flip != 0);
         if (v.bad_pre != 0) begin
            pre = '{8'h55, 8'h55, 8'h5D, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
         end else begin
            pre = make_pre(v.pre_n);
         end
         model_frame(v.bad_pre == 0, body);
         dv0 = dv_cnt;
         dc0 = done_cnt;
         send_frame(pre, body, 2);
         check($sformatf("v%0d_dv_count", k), 64'(dv_cnt - dv0), 64'(v.e_dv));
         check($sformatf("v%0d_done_count", k), 64'(done_cnt - dc0), 64'(v.e_done));
         if (v.e_done != 0 && done_cnt != dc0) begin
            if (v.ok_dc == 0) check($sformatf("v%0d_crc_ok", k), 64'(last_ok), 64'(v.e_ok));
            check($sformatf("v%0d_len_err", k), 64'(last_lerr), 64'(v.e_lerr));
            check($sformatf("v%0d_len", k), 64'(last_len), 64'(v.e_len));
            check($sformatf("v%0d_done_timing", k), 64'(done_edge), 64'(last_en_edge + 1));
         end
         if (v.e_dv != 0) begin
            check($sformatf("v%0d_latency", k), 64'(sof_edge + 1 - body0_edge), 64'd5);
         end
         check($sformatf("v%0d_frame_cnt", k), 64'(frame_cnt), 64'(v.e_done));
         check($sformatf("v%0d_bad_cnt", k), 64'(bad_cnt), 64'(v.e_bad));
         check($sformatf("v%0d_leftover", k), 64'(exp_q.size()), 64'd0);
      end

      // Back-to-back frames with a single idle cycle between them
      reset_dut();
      use_done_q = 1'b1;
      body = make_body(64, 1'b0, 1'b0);
      b2   = make_body(64, 1'b1, 1'b0);
      pre  = make_pre(7);
      model_frame(1'b1, body);
      model_frame(1'b1, b2);
      dv0 = dv_cnt;
      dc0 = done_cnt;
      send_frame(pre, body, 1);
      send_frame(pre, b2, 2);
      check("b2b_dv_count", 64'(dv_cnt - dv0), 64'd120);
      check("b2b_done_count", 64'(done_cnt - dc0), 64'd2);
      check("b2b_frame_cnt", 64'(frame_cnt), 64'd2);
      check("b2b_bad_cnt", 64'(bad_cnt), 64'd0);
      check("b2b_done_left", 64'(done_q.size()), 64'd0);

      // Reset for two cycles at payload byte 20, then a clean frame
      body = make_body(64, 1'b0, 1'b0);
      model_frame(1'b1, body);
      foreach (pre[i]) cycle(1'b1, pre[i]);
      dv0 = dv_cnt;
      for (int i = 0; i < 20; i++) cycle(1'b1, body[i]);
      check("rst_pre_dv_count", 64'(dv_cnt - dv0), 64'd16);
      sb_en = 1'b0;
      rst_n = 1'b0;
      cycle(1'b1, body[20]);
      check_all_zero("midrst");
      cycle(1'b1, body[21]);
      rst_n = 1'b1;
      exp_q.delete();
      exp_sof_q.delete();
      done_q.delete();
      exp_fc = 0;
      exp_bc = 0;
      sb_en = 1'b1;
      dv0 = dv_cnt;
      dc0 = done_cnt;
      for (int i = 22; i < 64; i++) cycle(1'b1, body[i]);
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h00);
      check("rst_drop_dv", 64'(dv_cnt - dv0), 64'd0);
      check("rst_drop_done", 64'(done_cnt - dc0), 64'd0);
      check("rst_drop_frame_cnt", 64'(frame_cnt), 64'd0);
      model_frame(1'b1, body);
      send_frame(pre, body, 2);
      check("rst_next_dv", 64'(dv_cnt - dv0), 64'd60);
      check("rst_next_frame_cnt", 64'(frame_cnt), 64'd1);
      check("rst_next_crc_ok", 64'(last_ok), 64'd1);

      // Randomized frames against the reference model
      reset_dut();
      use_done_q = 1'b1;
      for (int f = 0; f < 60; f++) begin
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 150));
         body = make_body(n, 1'b1, 1'b0);
         if (n > 0 && $urandom_range(0, 3) == 0) begin
            pos = int'($urandom_range(0, n - 1));
            body[pos] = body[pos] ^ (8'h01 << $urandom_range(0, 7));
         end
         pre_n = int'($urandom_range(1, 7));
         pre = make_pre(pre_n);
         if ($urandom_range(0, 5) == 0) begin
            pos = int'($urandom_range(0, pre_n));
            do r = 8'($urandom); while (r == 8'h55 || r == 8'hD5);
            pre[pos] = r;
            model_frame(1'b0, body);
         end else begin
            model_frame(1'b1, body);
         end
         gap = int'($urandom_range(1, 3));
         send_frame(pre, body, gap);
      end
      cycle(1'b0, 8'h00);
      check("rnd_frame_cnt", 64'(frame_cnt), 64'(exp_fc));
      check("rnd_bad_cnt", 64'(bad_cnt), 64'(exp_bc));
      check("rnd_payload_left", 64'(exp_q.size()), 64'd0);
      check("rnd_done_left", 64'(done_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
